// File: rtl/lane_draw_sequencer.sv
// Frame-tick driven scheduler feeding the shared 4x4 square plotter.
// Optional LANE_DRAW_SKIP_UNCHANGED_EN: redraw only slots that changed.
module lane_draw_sequencer #(
  parameter int unsigned LANE_LEN  = 26,
  parameter int unsigned X_ORIGIN  = 2,
  parameter int unsigned X_STEP    = 6,
  parameter int unsigned Y_RED     = 20,
  parameter int unsigned Y_YELLOW  = 50,
  parameter int unsigned Y_BLUE    = 80,
  parameter logic [3:0]  BUSY_WAIT = 4'd15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [LANE_LEN-1:0] red_seq,
  input  logic [LANE_LEN-1:0] yellow_seq,
  input  logic [LANE_LEN-1:0] blue_seq,
  input  logic                draw_busy,
  output logic                draw_start,
  output logic [7:0]          draw_x,
  output logic [6:0]          draw_y,
  output logic [2:0]          draw_colour,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          overrun_count
);

  localparam int unsigned SW = $clog2(LANE_LEN);
  localparam logic [SW-1:0] SLOT_LAST = SW'(LANE_LEN - 1);
  localparam logic [7:0] X0 = 8'(X_ORIGIN);
  localparam logic [7:0] XS = 8'(X_STEP);

  // Rightmost square must stay on the 160-pixel screen; timeout is reserved.
  if (X_ORIGIN + (LANE_LEN - 1) * X_STEP + 3 > 159 || BUSY_WAIT == 4'd0)
  begin : g_cfg_check
    $error("lane_draw_sequencer: bad geometry or reserved timeout");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_SCAN
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [7:0]          x_acc_q, x_acc_d;
  logic [LANE_LEN-1:0] red_q, red_d;
  logic [LANE_LEN-1:0] yel_q, yel_d;
  logic [LANE_LEN-1:0] blu_q, blu_d;
  logic [7:0]          ovr_q, ovr_d;

`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
  logic [LANE_LEN-1:0] red_prev_q, red_prev_d;
  logic [LANE_LEN-1:0] yel_prev_q, yel_prev_d;
  logic [LANE_LEN-1:0] blu_prev_q, blu_prev_d;
  logic                first_q, first_d;
  logic [LANE_LEN-1:0] prev_vec;
  logic                prev_bit;
`endif

  logic [LANE_LEN-1:0] cur_vec;
  logic                cur_bit;
  logic [6:0]          lane_y;
  logic [2:0]          lane_col;
  logic [2:0]          slot_col;
  logic                last_slot;
  logic                last_lane;
  logic                final_slot;
  logic [SW-1:0]       nxt_slot;
  logic [7:0]          nxt_x;
  logic [1:0]          nxt_lane;
  logic                drawing;

  always_comb begin
    cur_vec  = '0;
    lane_y   = '0;
    lane_col = '0;
    unique case (lane_q)
      2'd0: begin
        cur_vec  = red_q;
        lane_y   = 7'(Y_RED);
        lane_col = 3'b100;
      end
      2'd1: begin
        cur_vec  = yel_q;
        lane_y   = 7'(Y_YELLOW);
        lane_col = 3'b110;
      end
      2'd2: begin
        cur_vec  = blu_q;
        lane_y   = 7'(Y_BLUE);
        lane_col = 3'b001;
      end
      default: begin
        cur_vec  = '0;
        lane_y   = '0;
        lane_col = '0;
      end
    endcase
  end

`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
  always_comb begin
    prev_vec = '0;
    unique case (lane_q)
      2'd0:    prev_vec = red_prev_q;
      2'd1:    prev_vec = yel_prev_q;
      2'd2:    prev_vec = blu_prev_q;
      default: prev_vec = '0;
    endcase
  end
  assign prev_bit = prev_vec[slot_q];
`endif

  assign cur_bit    = cur_vec[slot_q];
  assign last_slot  = (slot_q == SLOT_LAST);
  assign last_lane  = (lane_q == 2'd2);
  assign final_slot = last_slot && last_lane;

  // Empty hit-column cells get a white marker so the target stays visible.
  assign slot_col = cur_bit   ? lane_col :
                    last_slot ? 3'b111   : 3'b000;

  // x advances by accumulation; wrap back to the origin on a lane change.
  assign nxt_slot = last_slot ? '0 : slot_q + SW'(1);
  assign nxt_x    = last_slot ? X0 : x_acc_q + XS;
  assign nxt_lane = last_slot ? lane_q + 2'd1 : lane_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    slot_d  = slot_q;
    x_acc_d = x_acc_q;
    red_d   = red_q;
    yel_d   = yel_q;
    blu_d   = blu_q;
    ovr_d   = ovr_q;
`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
    red_prev_d = red_prev_q;
    yel_prev_d = yel_prev_q;
    blu_prev_d = blu_prev_q;
    first_d    = first_q;
`endif
    if (frame_tick && state_q != S_IDLE && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          red_d   = red_seq;
          yel_d   = yellow_seq;
          blu_d   = blue_seq;
          lane_d  = 2'd0;
          slot_d  = '0;
          x_acc_d = X0;
`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
          state_d = S_SCAN;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!draw_busy) begin
          lane_d  = nxt_lane;
          slot_d  = nxt_slot;
          x_acc_d = nxt_x;
`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
          state_d = S_SCAN;
`else
          state_d = final_slot ? S_DONE : S_ISSUE;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
        red_prev_d = red_q;
        yel_prev_d = yel_q;
        blu_prev_d = blu_q;
        first_d    = 1'b0;
`endif
      end
`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
      S_SCAN: begin
        // lane 3 means every slot of blue has been visited
        if (lane_q == 2'd3) begin
          state_d = S_DONE;
        end else if (first_q || cur_bit != prev_bit) begin
          state_d = S_ISSUE;
        end else begin
          lane_d  = nxt_lane;
          slot_d  = nxt_slot;
          x_acc_d = nxt_x;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      slot_q  <= '0;
      x_acc_q <= '0;
      red_q   <= '0;
      yel_q   <= '0;
      blu_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      slot_q  <= slot_d;
      x_acc_q <= x_acc_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      blu_q   <= blu_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef LANE_DRAW_SKIP_UNCHANGED_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      red_prev_q <= '0;
      yel_prev_q <= '0;
      blu_prev_q <= '0;
      first_q    <= 1'b1;
    end else begin
      red_prev_q <= red_prev_d;
      yel_prev_q <= yel_prev_d;
      blu_prev_q <= blu_prev_d;
      first_q    <= first_d;
    end
  end
`endif

  assign drawing       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign draw_start    = (state_q == S_ISSUE);
  assign draw_x        = drawing ? x_acc_q  : '0;
  assign draw_y        = drawing ? lane_y   : '0;
  assign draw_colour   = drawing ? slot_col : '0;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign overrun_count = ovr_q;

endmodule
